// File: rtl/sha_pkg.sv
// Shared types and defaults for the SHA nonce-worker scheduler and its helpers.
// Latency and backpressure: none (declarations only).
package sha_pkg;

  localparam int DEF_NUM_WORKERS = 16;
  localparam int DEF_NUM_NONCES  = 16;
  localparam int DEF_TIMEOUT     = 1024;

  typedef logic [31:0] word_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_P2_GO,
    S_P2_WAIT,
    S_P3_GO,
    S_P3_WAIT,
    S_WRITE,
    S_FIN
  } sched_state_t;

endpackage

// File: rtl/sha_worker_sched_if.sv
// Worker broadcast/collect bus plus the shared memory write port.
// Latency and backpressure: none (wiring only); the memory port is write-only and always accepts.
interface sha_worker_sched_if #(
  parameter int NUM_WORKERS = sha_pkg::DEF_NUM_WORKERS
) ();

  logic                      wk_start;
  logic                      wk_phase_sel;
  logic [31:0]               wk_nonce_base;
  logic [NUM_WORKERS-1:0]    wk_finish;
  logic [32*NUM_WORKERS-1:0] wk_h0;
  logic                      mem_we;
  logic [15:0]               mem_addr;
  sha_pkg::word_t            mem_write_data;

  modport master (
    output wk_start, wk_phase_sel, wk_nonce_base, mem_we, mem_addr, mem_write_data,
    input  wk_finish, wk_h0
  );

  modport slave (
    input  wk_start, wk_phase_sel, wk_nonce_base, mem_we, mem_addr, mem_write_data,
    output wk_finish, wk_h0
  );

endinterface

// File: rtl/sched_watchdog.sv
// Wait-state watchdog: counter cleared by clr, advanced by en; tc flags the LIMIT-th enabled cycle.
// Latency: tc is combinational from the count; no backpressure, saturates at the terminal value.
module sched_watchdog #(
  parameter int unsigned LIMIT = 1024
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && !tc) begin
      count <= count + W'(1);
    end
  end

  // count holds the number of wait cycles already spent, so tc marks the current one as the last allowed
  assign tc = (count == W'(LIMIT - 1));

endmodule

// File: rtl/sha_worker_sched.sv
// Sequences nonce batches through the workers (phase 2, phase 3) and streams each worker's H0 to memory.
// Latency per batch: T2 + T3 + NUM_WORKERS cycles plus FIN; no backpressure, one write per cycle.
module sha_worker_sched
  import sha_pkg::*;
#(
  parameter int NUM_WORKERS = DEF_NUM_WORKERS,
  parameter int NUM_NONCES  = DEF_NUM_NONCES,
  parameter int TIMEOUT     = DEF_TIMEOUT
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      start,
  input  logic [15:0]               output_addr,
  output logic                      busy,
  output logic                      done,
  output logic                      error,
  sha_worker_sched_if.master        wk
);

  localparam int NUM_BATCHES = NUM_NONCES / NUM_WORKERS;
  localparam int IW = (NUM_WORKERS > 1) ? $clog2(NUM_WORKERS) : 1;
  localparam int BW = (NUM_BATCHES > 1) ? $clog2(NUM_BATCHES) : 1;

  sched_state_t           state;
  sched_state_t           state_nxt;
  logic [NUM_WORKERS-1:0] mask;
  logic [NUM_WORKERS-1:0] mask_nxt;
  logic [BW-1:0]          batch;
  logic [IW-1:0]          wr_idx;
  logic [31:0]            nonce_base;
  logic                   phase_q;
  word_t                  res_buf [NUM_WORKERS];

  logic mask_full;
  logic last_word;
  logic last_batch;
  logic in_wait;
  logic in_go;
  logic wd_tc;

  assign mask_nxt   = mask | wk.wk_finish;
  assign mask_full  = (mask_nxt == '1);
  assign last_word  = (wr_idx == IW'(NUM_WORKERS - 1));
  assign last_batch = (batch == BW'(NUM_BATCHES - 1));
  assign in_wait    = (state == S_P2_WAIT) || (state == S_P3_WAIT);
  assign in_go      = (state == S_P2_GO) || (state == S_P3_GO);

  sched_watchdog #(
    .LIMIT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (in_go),
    .en      (in_wait),
    .tc      (wd_tc)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:    if (start) state_nxt = S_P2_GO;
      S_P2_GO:   state_nxt = S_P2_WAIT;
      S_P2_WAIT: begin
        if (mask_full)  state_nxt = S_P3_GO;
        else if (wd_tc) state_nxt = S_IDLE;
      end
      S_P3_GO:   state_nxt = S_P3_WAIT;
      S_P3_WAIT: begin
        if (mask_full)  state_nxt = S_WRITE;
        else if (wd_tc) state_nxt = S_IDLE;
      end
      S_WRITE:   if (last_word) state_nxt = last_batch ? S_FIN : S_P2_GO;
      S_FIN:     state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy              = (state != S_IDLE);
    done              = (state == S_FIN);
    wk.wk_start       = in_go;
    wk.mem_we         = (state == S_WRITE);
    wk.mem_addr       = '0;
    wk.mem_write_data = '0;
    if (state == S_P2_GO) begin
      wk.wk_phase_sel = 1'b0;
    end else if (state == S_P3_GO) begin
      wk.wk_phase_sel = 1'b1;
    end else begin
      wk.wk_phase_sel = phase_q;
    end
    if (state == S_WRITE) begin
      wk.mem_addr       = output_addr + nonce_base[15:0] + 16'(wr_idx);
      wk.mem_write_data = res_buf[wr_idx];
    end
  end

  assign wk.wk_nonce_base = nonce_base;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask       <= '0;
      batch      <= '0;
      wr_idx     <= '0;
      nonce_base <= '0;
      phase_q    <= 1'b0;
      error      <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            error      <= 1'b0;
            batch      <= '0;
            nonce_base <= '0;
          end
        end
        S_P2_GO: begin
          mask    <= '0;
          wr_idx  <= '0;
          phase_q <= 1'b0;
        end
        S_P3_GO: begin
          mask    <= '0;
          phase_q <= 1'b1;
        end
        S_P2_WAIT, S_P3_WAIT: begin
          mask <= mask_nxt;
          if (!mask_full && wd_tc) error <= 1'b1;
        end
        S_WRITE: begin
          wr_idx <= wr_idx + IW'(1);
          // base advances on the last word so it stays stable across the whole batch
          if (last_word && !last_batch) begin
            batch      <= batch + BW'(1);
            nonce_base <= nonce_base + 32'(NUM_WORKERS);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == S_P3_WAIT && mask_full) begin
      for (int i = 0; i < NUM_WORKERS; i++) begin
        res_buf[i] <= wk.wk_h0[32*i +: 32];
      end
    end
  end

endmodule
